// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the memory/write-back stage:
// funct3 codes, write-back select values, store lane enables and load extension.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_PC4 = 2'd1,
    WB_MEM = 2'd2
  } wb_sel_t;

  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] addr);
    logic [3:0] en;
    case (funct3)
      F3_SB:   en = 4'b0001 << addr;
      F3_SH:   en = 4'b0011 << {addr[1], 1'b0};
      F3_SW:   en = 4'b1111;
      default: en = 4'b0000;
    endcase
    return en;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] funct3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_LB:   res = {{24{b[7]}}, b};
      F3_LBU:  res = {24'h000000, b};
      F3_LH:   res = {{16{h[15]}}, h};
      F3_LHU:  res = {16'h0000, h};
      F3_LW:   res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Only real memory operations with a valid size can fault; invalid funct3 never does.
  function automatic logic misaligned(input logic is_ld, input logic is_st,
                                      input logic [2:0] funct3, input logic [1:0] addr);
    logic m;
    m = 1'b0;
    if (is_ld) begin
      case (funct3)
        F3_LH, F3_LHU: m = addr[0];
        F3_LW:         m = (addr != 2'b00);
        default:       m = 1'b0;
      endcase
    end else if (is_st) begin
      case (funct3)
        F3_SH:   m = addr[0];
        F3_SW:   m = (addr != 2'b00);
        default: m = 1'b0;
      endcase
    end else begin
      m = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_wb_stage_data_ram.sv
// Word-organised synchronous data RAM with per-byte write enables and a registered read port.
module data_ram #(
  parameter int SIZE    = 1024,
  parameter int LOGSIZE = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic [3:0]         we,
  input  logic               re,
  input  logic [LOGSIZE-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [SIZE];

  // Byte-lane writes and registered read; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: steers stores into the data RAM, launches loads,
// flags misaligned accesses and registers the write-back triple for the register file.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SIZE  = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_EXMEM,
  input  logic [WIDTH-1:0] ALU_out_EXMEM,
  input  logic [2:0]       funct3_EXMEM,
  input  logic             mem_rd_en_EXMEM,
  input  logic             mem_wr_en_EXMEM,
  input  logic [WIDTH-1:0] rs2_data_EXMEM,
  input  logic             reg_wr_en_EXMEM,
  input  logic [1:0]       reg_wr_ctrl_EXMEM,
  input  logic [4:0]       rd_EXMEM,
  input  logic [WIDTH-1:0] pc_4_EXMEM,
  input  logic             stall_MEM,
  output logic [WIDTH-1:0] reg_wr_data_WBID,
  output logic [4:0]       rd_WBID,
  output logic             reg_wr_en_WBID,
  output logic             misaligned_WB,
  output logic [WIDTH-1:0] fault_addr_WB
);

  localparam int LOGSIZE = $clog2(SIZE);

  logic               accept;
  logic               mis;
  logic               ram_re;
  logic [3:0]         ram_we;
  logic [WIDTH-1:0]   ram_wdata;
  logic [WIDTH-1:0]   ram_rdata;
  logic [LOGSIZE-1:0] word_idx;

  logic               wb_en;
  logic [4:0]         wb_rd;
  logic [1:0]         wb_ctrl;
  logic [2:0]         wb_funct3;
  logic [1:0]         wb_off;
  logic [WIDTH-1:0]   wb_alu;
  logic [WIDTH-1:0]   wb_pc4;
  logic               wb_mis;
  logic [WIDTH-1:0]   wb_fault_addr;
  logic [WIDTH-1:0]   wb_data;

  assign word_idx = ALU_out_EXMEM[LOGSIZE+1:2];

  // Accept, fault detection and store lane steering; a store in the reset cycle is dropped.
  always_comb begin
    accept    = valid_EXMEM & ~stall_MEM;
    mis       = accept & misaligned(mem_rd_en_EXMEM, mem_wr_en_EXMEM, funct3_EXMEM,
                                    ALU_out_EXMEM[1:0]);
    ram_re    = accept & mem_rd_en_EXMEM;
    ram_we    = 4'b0000;
    ram_wdata = rs2_data_EXMEM;
    if (accept && mem_wr_en_EXMEM && !mis && !reset) begin
      ram_we = byte_en(funct3_EXMEM, ALU_out_EXMEM[1:0]);
    end else begin
      ram_we = 4'b0000;
    end
    case (funct3_EXMEM)
      F3_SB:   ram_wdata = {4{rs2_data_EXMEM[7:0]}};
      F3_SH:   ram_wdata = {2{rs2_data_EXMEM[15:0]}};
      default: ram_wdata = rs2_data_EXMEM;
    endcase
  end

  data_ram #(.SIZE(SIZE), .LOGSIZE(LOGSIZE)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (word_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Stage register; rejected cycles become bubbles while the rest of the slot holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en         <= 1'b0;
      wb_rd         <= 5'd0;
      wb_ctrl       <= 2'd0;
      wb_funct3     <= 3'd0;
      wb_off        <= 2'd0;
      wb_alu        <= '0;
      wb_pc4        <= '0;
      wb_mis        <= 1'b0;
      wb_fault_addr <= '0;
    end else begin
      wb_en  <= accept & reg_wr_en_EXMEM & ~mis;
      wb_mis <= mis;
      if (accept) begin
        wb_rd     <= rd_EXMEM;
        wb_ctrl   <= reg_wr_ctrl_EXMEM;
        wb_funct3 <= funct3_EXMEM;
        wb_off    <= ALU_out_EXMEM[1:0];
        wb_alu    <= ALU_out_EXMEM;
        wb_pc4    <= pc_4_EXMEM;
      end
      if (mis) begin
        wb_fault_addr <= ALU_out_EXMEM;
      end
    end
  end

  // Write-back select; load data comes straight from the RAM's output register.
  always_comb begin
    wb_data = '0;
    case (wb_ctrl)
      WB_ALU:  wb_data = wb_alu;
      WB_PC4:  wb_data = wb_pc4;
      WB_MEM:  wb_data = load_ext(wb_funct3, wb_off, ram_rdata);
      default: wb_data = '0;
    endcase
  end

  assign reg_wr_data_WBID = wb_data;
  assign rd_WBID          = wb_rd;
  assign reg_wr_en_WBID   = wb_en;
  assign misaligned_WB    = wb_mis;
  assign fault_addr_WB    = wb_fault_addr;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: one task per scenario, hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_EXMEM;
  logic [31:0] ALU_out_EXMEM;
  logic [2:0]  funct3_EXMEM;
  logic        mem_rd_en_EXMEM;
  logic        mem_wr_en_EXMEM;
  logic [31:0] rs2_data_EXMEM;
  logic        reg_wr_en_EXMEM;
  logic [1:0]  reg_wr_ctrl_EXMEM;
  logic [4:0]  rd_EXMEM;
  logic [31:0] pc_4_EXMEM;
  logic        stall_MEM;
  logic [31:0] reg_wr_data_WBID;
  logic [4:0]  rd_WBID;
  logic        reg_wr_en_WBID;
  logic        misaligned_WB;
  logic [31:0] fault_addr_WB;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.WIDTH(32), .SIZE(1024)) dut (
    .clk               (clk),
    .reset             (reset),
    .valid_EXMEM       (valid_EXMEM),
    .ALU_out_EXMEM     (ALU_out_EXMEM),
    .funct3_EXMEM      (funct3_EXMEM),
    .mem_rd_en_EXMEM   (mem_rd_en_EXMEM),
    .mem_wr_en_EXMEM   (mem_wr_en_EXMEM),
    .rs2_data_EXMEM    (rs2_data_EXMEM),
    .reg_wr_en_EXMEM   (reg_wr_en_EXMEM),
    .reg_wr_ctrl_EXMEM (reg_wr_ctrl_EXMEM),
    .rd_EXMEM          (rd_EXMEM),
    .pc_4_EXMEM        (pc_4_EXMEM),
    .stall_MEM         (stall_MEM),
    .reg_wr_data_WBID  (reg_wr_data_WBID),
    .rd_WBID           (rd_WBID),
    .reg_wr_en_WBID    (reg_wr_en_WBID),
    .misaligned_WB     (misaligned_WB),
    .fault_addr_WB     (fault_addr_WB)
  );

  // Present one slot, then wait past the next rising edge so WB outputs reflect it.
  task automatic drive(input logic v, input logic [31:0] a, input logic [2:0] f3,
                       input logic rde, input logic wre, input logic [31:0] d,
                       input logic rwe, input logic [1:0] ctrl, input logic [4:0] rd);
    valid_EXMEM       = v;
    ALU_out_EXMEM     = a;
    funct3_EXMEM      = f3;
    mem_rd_en_EXMEM   = rde;
    mem_wr_en_EXMEM   = wre;
    rs2_data_EXMEM    = d;
    reg_wr_en_EXMEM   = rwe;
    reg_wr_ctrl_EXMEM = ctrl;
    rd_EXMEM          = rd;
    pc_4_EXMEM        = a + 32'h0000_1004;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d);
    drive(1'b1, a, f3, 1'b0, 1'b1, d, 1'b0, 2'd0, 5'd0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd);
    drive(1'b1, a, f3, 1'b1, 1'b0, 32'h0, 1'b1, 2'd2, rd);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 5'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_MEM = 1'b0;
    idle(); idle();
    reset = 1'b0;
    tests++; if (reg_wr_data_WBID !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 0", reg_wr_data_WBID); end
    tests++; if (rd_WBID !== 5'd0) begin fails++; $display("FAIL reset_rd got %0d want 0", rd_WBID); end
    tests++; if (reg_wr_en_WBID !== 1'b0) begin fails++; $display("FAIL reset_en got %b want 0", reg_wr_en_WBID); end
    tests++; if (misaligned_WB !== 1'b0) begin fails++; $display("FAIL reset_mis got %b want 0", misaligned_WB); end
    tests++; if (fault_addr_WB !== 32'h0) begin fails++; $display("FAIL reset_faddr got %h want 0", fault_addr_WB); end
  endtask

  task automatic test_word();
    st(32'h10, 3'b010, 32'hDEADBEEF);
    tests++; if (reg_wr_en_WBID !== 1'b0) begin fails++; $display("FAIL sw_en got %b want 0", reg_wr_en_WBID); end
    ld(32'h10, 3'b010, 5'd5);
    tests++; if (reg_wr_data_WBID !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_data got %h want deadbeef", reg_wr_data_WBID); end
    tests++; if (rd_WBID !== 5'd5 || reg_wr_en_WBID !== 1'b1) begin fails++; $display("FAIL lw_rd_en got rd=%0d en=%b want rd=5 en=1", rd_WBID, reg_wr_en_WBID); end
  endtask

  task automatic test_byte();
    st(32'h13, 3'b000, 32'h12345680);
    ld(32'h13, 3'b000, 5'd6);
    tests++; if (reg_wr_data_WBID !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_data got %h want ffffff80", reg_wr_data_WBID); end
    ld(32'h13, 3'b100, 5'd6);
    tests++; if (reg_wr_data_WBID !== 32'h00000080) begin fails++; $display("FAIL lbu_data got %h want 00000080", reg_wr_data_WBID); end
    ld(32'h10, 3'b010, 5'd6);
    tests++; if (reg_wr_data_WBID !== 32'h80ADBEEF) begin fails++; $display("FAIL sb_lw_data got %h want 80adbeef", reg_wr_data_WBID); end
  endtask

  task automatic test_half();
    st(32'h20, 3'b010, 32'h12348765);
    ld(32'h22, 3'b001, 5'd7);
    tests++; if (reg_wr_data_WBID !== 32'h00001234) begin fails++; $display("FAIL lh_hi got %h want 00001234", reg_wr_data_WBID); end
    ld(32'h22, 3'b101, 5'd7);
    tests++; if (reg_wr_data_WBID !== 32'h00001234) begin fails++; $display("FAIL lhu_hi got %h want 00001234", reg_wr_data_WBID); end
    ld(32'h20, 3'b001, 5'd7);
    tests++; if (reg_wr_data_WBID !== 32'hFFFF8765) begin fails++; $display("FAIL lh_lo got %h want ffff8765", reg_wr_data_WBID); end
    ld(32'h20, 3'b101, 5'd7);
    tests++; if (reg_wr_data_WBID !== 32'h00008765) begin fails++; $display("FAIL lhu_lo got %h want 00008765", reg_wr_data_WBID); end
    st(32'h22, 3'b001, 32'h5555ABCD);
    ld(32'h20, 3'b010, 5'd7);
    tests++; if (reg_wr_data_WBID !== 32'hABCD8765) begin fails++; $display("FAIL sh_lw got %h want abcd8765", reg_wr_data_WBID); end
  endtask

  task automatic test_wb_sel();
    drive(1'b1, 32'h000055AB, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 2'd0, 5'd9);
    tests++; if (reg_wr_data_WBID !== 32'h000055AB || rd_WBID !== 5'd9 || reg_wr_en_WBID !== 1'b1) begin fails++; $display("FAIL wb_alu got %h rd=%0d en=%b want 000055ab rd=9 en=1", reg_wr_data_WBID, rd_WBID, reg_wr_en_WBID); end
    drive(1'b1, 32'h00000003, 3'b010, 1'b0, 1'b0, 32'h0, 1'b1, 2'd1, 5'd1);
    tests++; if (reg_wr_data_WBID !== 32'h00001007) begin fails++; $display("FAIL wb_pc4 got %h want 00001007", reg_wr_data_WBID); end
    tests++; if (misaligned_WB !== 1'b0) begin fails++; $display("FAIL nonmem_fault got %b want 0", misaligned_WB); end
    drive(1'b1, 32'h12345678, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 2'd3, 5'd2);
    tests++; if (reg_wr_data_WBID !== 32'h0) begin fails++; $display("FAIL wb_rsvd got %h want 0", reg_wr_data_WBID); end
  endtask

  task automatic test_misalign();
    st(32'h04, 3'b010, 32'h11223344);
    st(32'h06, 3'b010, 32'hFFFFFFFF);
    tests++; if (misaligned_WB !== 1'b1 || fault_addr_WB !== 32'h6 || reg_wr_en_WBID !== 1'b0) begin fails++; $display("FAIL sw_mis got mis=%b fa=%h en=%b want 1 6 0", misaligned_WB, fault_addr_WB, reg_wr_en_WBID); end
    idle();
    tests++; if (misaligned_WB !== 1'b0 || fault_addr_WB !== 32'h6) begin fails++; $display("FAIL mis_pulse got mis=%b fa=%h want 0 6", misaligned_WB, fault_addr_WB); end
    ld(32'h04, 3'b010, 5'd3);
    tests++; if (reg_wr_data_WBID !== 32'h11223344) begin fails++; $display("FAIL mis_nowrite got %h want 11223344", reg_wr_data_WBID); end
    ld(32'h42, 3'b010, 5'd3);
    tests++; if (misaligned_WB !== 1'b1 || reg_wr_en_WBID !== 1'b0 || fault_addr_WB !== 32'h42) begin fails++; $display("FAIL lw_mis got mis=%b en=%b fa=%h want 1 0 42", misaligned_WB, reg_wr_en_WBID, fault_addr_WB); end
    ld(32'h45, 3'b001, 5'd3);
    tests++; if (misaligned_WB !== 1'b1 || fault_addr_WB !== 32'h45) begin fails++; $display("FAIL lh_mis got mis=%b fa=%h want 1 45", misaligned_WB, fault_addr_WB); end
    ld(32'h07, 3'b000, 5'd3);
    tests++; if (misaligned_WB !== 1'b0 || reg_wr_en_WBID !== 1'b1 || reg_wr_data_WBID !== 32'h00000011) begin fails++; $display("FAIL lb_ok got mis=%b en=%b d=%h want 0 1 00000011", misaligned_WB, reg_wr_en_WBID, reg_wr_data_WBID); end
  endtask

  task automatic test_stall();
    st(32'h40, 3'b010, 32'hCAFEF00D);
    stall_MEM = 1'b1;
    ld(32'h40, 3'b010, 5'd8);
    tests++; if (reg_wr_en_WBID !== 1'b0) begin fails++; $display("FAIL stall1_en got %b want 0", reg_wr_en_WBID); end
    ld(32'h40, 3'b010, 5'd8);
    tests++; if (reg_wr_en_WBID !== 1'b0) begin fails++; $display("FAIL stall2_en got %b want 0", reg_wr_en_WBID); end
    stall_MEM = 1'b0;
    ld(32'h40, 3'b010, 5'd8);
    tests++; if (reg_wr_en_WBID !== 1'b1 || reg_wr_data_WBID !== 32'hCAFEF00D || rd_WBID !== 5'd8) begin fails++; $display("FAIL stall_wb got en=%b d=%h rd=%0d want 1 cafef00d 8", reg_wr_en_WBID, reg_wr_data_WBID, rd_WBID); end
    idle();
    tests++; if (reg_wr_en_WBID !== 1'b0) begin fails++; $display("FAIL stall_once got %b want 0", reg_wr_en_WBID); end
    stall_MEM = 1'b1;
    st(32'h40, 3'b010, 32'h0);
    stall_MEM = 1'b0;
    ld(32'h40, 3'b010, 5'd8);
    tests++; if (reg_wr_data_WBID !== 32'hCAFEF00D) begin fails++; $display("FAIL stalled_st got %h want cafef00d", reg_wr_data_WBID); end
  endtask

  task automatic test_wrap_x0();
    st(32'h0000_1008, 3'b010, 32'h0BADCAFE);
    ld(32'h0000_0008, 3'b010, 5'd0);
    tests++; if (reg_wr_data_WBID !== 32'h0BADCAFE || reg_wr_en_WBID !== 1'b1 || rd_WBID !== 5'd0) begin fails++; $display("FAIL wrap_x0 got d=%h en=%b rd=%0d want 0badcafe 1 0", reg_wr_data_WBID, reg_wr_en_WBID, rd_WBID); end
  endtask

  task automatic test_reset_store();
    st(32'h0, 3'b010, 32'hA5A5A5A5);
    ld(32'h10, 3'b010, 5'd4);
    reset = 1'b1;
    st(32'h0, 3'b010, 32'h0BADF00D);
    reset = 1'b0;
    tests++; if (reg_wr_data_WBID !== 32'h0 || rd_WBID !== 5'd0 || reg_wr_en_WBID !== 1'b0 || misaligned_WB !== 1'b0 || fault_addr_WB !== 32'h0) begin fails++; $display("FAIL rst_mid got d=%h rd=%0d en=%b mis=%b fa=%h want all 0", reg_wr_data_WBID, rd_WBID, reg_wr_en_WBID, misaligned_WB, fault_addr_WB); end
    ld(32'h0, 3'b010, 5'd4);
    tests++; if (reg_wr_data_WBID !== 32'hA5A5A5A5) begin fails++; $display("FAIL rst_store got %h want a5a5a5a5", reg_wr_data_WBID); end
  endtask

  initial begin
    reset = 1'b1;
    stall_MEM = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_wb_sel();
    test_misalign();
    test_stall();
    test_wrap_x0();
    test_reset_store();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
